// File: rtl/des_pkg.sv
// Shared DES substitution-layer definitions: S-box and P tables, FSM states, lane helpers.
// The P table is only consumed when DES_SBOX_PERM_EN is defined.
package des_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } des_state_t;

   // Indexed [sbox][row*16 + col]; sbox 0 is S1.
   localparam logic [3:0] SBOX [8][64] = '{
      '{4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
        4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
        4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
        4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13},
      '{4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10,
        4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5,
        4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15,
        4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9},
      '{4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8,
        4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
        4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7,
        4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12},
      '{4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15,
        4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9,
        4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4,
        4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14},
      '{4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9,
        4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6,
        4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14,
        4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3},
      '{4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11,
        4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8,
        4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6,
        4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13},
      '{4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1,
        4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6,
        4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2,
        4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12},
      '{4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7,
        4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2,
        4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8,
        4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11}
   };

   // Output bit i (DES numbering from 1) takes input bit PERM[i-1].
   localparam int unsigned PERM [32] = '{
      16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
      2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
   };

   function automatic bit lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
   endfunction

   function automatic int groups_of(input int lanes);
      return (lanes > 0) ? (8 / lanes) : 1;
   endfunction

   function automatic int grp_width(input int groups);
      return (groups > 1) ? $clog2(groups) : 1;
   endfunction

   function automatic logic [31:0] p_permute(input logic [31:0] s);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[31-i] = s[5'(32 - PERM[i])];
      end
      return r;
   endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// One DES S-box lookup: 6-bit chunk in DES order (b1 = MSB) to 4-bit nibble, table chosen by sbox_sel.
module des_sbox_lut
   import des_pkg::*;
(
   input  logic [2:0] sbox_sel,
   input  logic [5:0] chunk,
   output logic [3:0] nib
);

   logic [5:0] idx;

   // row = {b1,b6}, col = b2..b5
   assign idx = {chunk[5], chunk[0], chunk[4:1]};
   assign nib = SBOX[sbox_sel][idx];

endmodule

// File: rtl/des_sbox_bank.sv
// DES S1..S8 substitution layer behind valid/ready, LANES S-boxes per cycle.
// Define DES_SBOX_PERM_EN to apply the P-permutation ahead of the output register.
//
// state   | meaning
// IDLE    | waiting for an input word, in_ready high
// RUN     | evaluating one group of LANES S-boxes per cycle
// DONE    | result presented, held until out_ready
module des_sbox_bank
   import des_pkg::*;
#(
   parameter int LANES = 8
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   localparam int GROUPS = groups_of(LANES);
   localparam int GW     = grp_width(GROUPS);
   localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);

   if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("des_sbox_bank: LANES must be 1, 2, 4 or 8");
   end

   des_state_t    state_q, state_d;
   logic [GW-1:0] grp_q, grp_d;
   logic [47:0]   in_q, in_d;
   logic [31:0]   res_q, res_d;
   logic [31:0]   out_q, out_d;
   logic [31:0]   res_upd, res_fmt;
   logic          rdy_c, vld_c;

   logic [2:0] sel   [LANES];
   logic [5:0] chunk [LANES];
   logic [3:0] nib   [LANES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign sel[l]   = 3'(int'(grp_q) * LANES + l);
      assign chunk[l] = in_q[6*(7 - int'(sel[l])) +: 6];
      des_sbox_lut u_lut (
         .sbox_sel (sel[l]),
         .chunk    (chunk[l]),
         .nib      (nib[l])
      );
   end

   // Nibbles of groups not yet evaluated keep their old value; out_valid gates use.
   always_comb begin
      res_upd = res_q;
      for (int l = 0; l < LANES; l++) begin
         res_upd[4*(7 - int'(sel[l])) +: 4] = nib[l];
      end
   end

`ifdef DES_SBOX_PERM_EN
   assign res_fmt = p_permute(res_upd);
`else
   assign res_fmt = res_upd;
`endif

   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      in_d    = in_q;
      res_d   = res_q;
      out_d   = out_q;
      rdy_c   = 1'b0;
      vld_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rdy_c = 1'b1;
            if (in_valid) begin
               in_d    = in_data;
               grp_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            res_d = res_upd;
            if (grp_q == GRP_LAST) begin
               out_d   = res_fmt;
               state_d = ST_DONE;
            end else begin
               grp_d = grp_q + GW'(1);
            end
         end
         ST_DONE: begin
            vld_c = 1'b1;
            rdy_c = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  in_d    = in_data;
                  grp_d   = '0;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grp_q   <= '0;
         in_q    <= '0;
         res_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         in_q    <= in_d;
         res_q   <= res_d;
         out_q   <= out_d;
      end
   end

   // The reset state is IDLE, so in_ready must also be held low by rst_n itself.
   assign in_ready  = rdy_c & rst_n;
   assign out_valid = vld_c;
   assign out_data  = out_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
